// File: rtl/mybus_resp_mc.sv
// mybus_resp_mc : multi-channel MyBus responder.
//
// Each of NCH request channels pushes {data} into its own DEPTH-entry FIFO
// when start[i] is seen while ready[i] is high. Buffered words are drained
// round-robin onto a single registered valid/ack output port.
//
// Ports:
//   ck         clock
//   srst_n     synchronous active-low reset
//   start      per-channel request strobe
//   data       per-channel request data, channel i at [i*DATA_W +: DATA_W]
//   ready      registered per-channel "can accept" flag
//   dataReady  registered output valid
//   dataOut    registered output data
//   chOut      source channel of dataOut
//   dataAck    consumer accepts dataOut
//   ovf        sticky per-channel overflow (request dropped while !ready)
//   clr_ovf    clears ovf (and parErr); a same-cycle drop still sets its bit
//   dataPar    (MYBUS_RESP_PARITY_EN) even parity of {chOut, dataOut}
//   parErr     (MYBUS_RESP_PARITY_EN) sticky stored-parity mismatch flag
//
// Optional feature macro: MYBUS_RESP_PARITY_EN

module mybus_resp_mc #(
    parameter int NCH    = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                   ck,
    input  logic                   srst_n,
    input  logic [NCH-1:0]         start,
    input  logic [NCH*DATA_W-1:0]  data,
    output logic [NCH-1:0]         ready,
    output logic                   dataReady,
    output logic [DATA_W-1:0]      dataOut,
    output logic [$clog2(NCH)-1:0] chOut,
    input  logic                   dataAck,
    output logic [NCH-1:0]         ovf,
`ifdef MYBUS_RESP_PARITY_EN
    output logic                   dataPar,
    output logic                   parErr,
`endif
    input  logic                   clr_ovf
);

    localparam int CH_W = $clog2(NCH);
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
`ifdef MYBUS_RESP_PARITY_EN
    localparam int EW   = DATA_W + 1;   // {parity, data}
`else
    localparam int EW   = DATA_W;
`endif

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t          state_q, state_nxt;
    logic [EW-1:0]   mem [NCH][DEPTH];
    logic [EW-1:0]   wr_entry [NCH];
    logic [PW-1:0]   wr_ptr [NCH];
    logic [PW-1:0]   rd_ptr [NCH];
    logic [CW-1:0]   count_q [NCH];
    logic [CW-1:0]   count_nxt [NCH];
    logic [NCH-1:0]  push, pop, nonempty;
    logic [CH_W-1:0] last_grant, grant_idx;
    logic            grant_valid, load;
    logic [EW-1:0]   rd_entry;

    // Acceptance uses only the registered ready, never the current pop.
    assign push = start & ready;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
`ifdef MYBUS_RESP_PARITY_EN
            wr_entry[i] = {^data[i*DATA_W +: DATA_W], data[i*DATA_W +: DATA_W]};
`else
            wr_entry[i] = data[i*DATA_W +: DATA_W];
`endif
            nonempty[i]  = (count_q[i] != '0);
            count_nxt[i] = count_q[i] + CW'(push[i]) - CW'(pop[i]);
        end
    end

    // Round-robin scan starting just after the last granted channel. Only
    // entries already stored (registered counts) are eligible.
    always_comb begin
        int              idx;
        logic [CH_W-1:0] cidx;
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= NCH; k++) begin
            idx  = (int'(last_grant) + k) % NCH;
            cidx = CH_W'(idx);
            if (!grant_valid && nonempty[cidx]) begin
                grant_valid = 1'b1;
                grant_idx   = cidx;
            end
        end
    end

    assign rd_entry = mem[grant_idx][rd_ptr[grant_idx]];

    // Output FSM: state register.
    always_ff @(posedge ck) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!srst_n) state_q <= IDLE;
        else         state_q <= state_nxt;
    end

    // Output FSM: next state. In HOLD an ack with more data reloads in place.
    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            IDLE: state_nxt = grant_valid ? HOLD : IDLE;
            HOLD: if (dataAck) state_nxt = grant_valid ? HOLD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output FSM: outputs / control decode.
    always_comb begin
        load = grant_valid && ((state_q == IDLE) || dataAck);
        pop  = '0;
        if (load) pop[grant_idx] = 1'b1;
        dataReady = (state_q == HOLD);
    end

    // FIFO bookkeeping, ready, overflow and arbitration history.
    always_ff @(posedge ck) begin
        if (!srst_n) begin
            last_grant <= CH_W'(NCH - 1);   // channel 0 wins first after reset
            ready      <= '0;
            ovf        <= '0;
            for (int i = 0; i < NCH; i++) begin
                wr_ptr[i]  <= '0;
                rd_ptr[i]  <= '0;
                count_q[i] <= '0;
            end
        end else begin
            if (load) last_grant <= grant_idx;
            for (int i = 0; i < NCH; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
                count_q[i] <= count_nxt[i];
                ready[i]   <= (count_nxt[i] < CW'(DEPTH));
            end
            // Set wins over clear for a drop in the same cycle as clr_ovf.
            ovf <= (clr_ovf ? '0 : ovf) | (start & ~ready);
        end
    end

    // NOTE: FIFO storage has no reset; validity is tracked by the counts alone.
    always_ff @(posedge ck) begin
        for (int i = 0; i < NCH; i++) begin
            if (push[i]) mem[i][wr_ptr[i]] <= wr_entry[i];
        end
    end

    // Output data path: loaded on a grant, held otherwise.
    always_ff @(posedge ck) begin
        if (!srst_n) begin
            dataOut <= '0;
            chOut   <= '0;
`ifdef MYBUS_RESP_PARITY_EN
            dataPar <= 1'b0;
            parErr  <= 1'b0;
`endif
        end else begin
            if (load) begin
                dataOut <= rd_entry[DATA_W-1:0];
                chOut   <= grant_idx;
`ifdef MYBUS_RESP_PARITY_EN
                dataPar <= ^{grant_idx, rd_entry[DATA_W-1:0]};
`endif
            end
`ifdef MYBUS_RESP_PARITY_EN
            parErr <= (clr_ovf ? 1'b0 : parErr) |
                      (load && (rd_entry[DATA_W] != ^rd_entry[DATA_W-1:0]));
`endif
        end
    end

endmodule
